// File: rtl/fft_stream_core.sv
// rtl/fft_stream_core.sv - streaming in-place radix-2 DIT FFT engine with one shared butterfly
//
// Collects N = 2^LOG2N complex samples (stored at bit-reversed addresses), runs
// LOG2N*N/2 butterflies one per cycle in place, then streams the spectrum out in
// natural order. LOAD, CALC and UNLOAD never overlap.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   data_in holds a sample          in_ready   sample accepted this cycle (LOAD)
//   data_in    {re, im}, DW bits each           inverse    direction, latched with sample 0
//   out_valid  data_out holds a result          out_ready  consumer takes data_out
//   data_out   {re, im}, DW bits each           busy       butterfly sequence running
module fft_stream_core #(
   parameter int LOG2N = 3,
   parameter int DW    = 17,
   parameter int TW    = 16,
   parameter int SCALE = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2*DW-1:0] data_in,
   input  logic            inverse,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [2*DW-1:0] data_out,
   output logic            busy
);
   localparam int N     = 1 << LOG2N;
   localparam int HB    = LOG2N - 1;          // butterfly index width
   localparam int SW    = $clog2(LOG2N);      // stage index width
   localparam int PW    = DW + TW + 1;        // width of a product sum
   localparam int AW    = DW + 2;             // butterfly add/sub width
   localparam int TW_UP = (TW >= 16) ? TW - 16 : 0;
   localparam int TW_DN = (TW < 16) ? 16 - TW : 0;

   localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);
   localparam logic [HB-1:0]    LAST_B   = HB'(N / 2 - 1);
   localparam logic [SW-1:0]    LAST_S   = SW'(LOG2N - 1);
   localparam logic signed [AW-1:0] MAX_V = $signed({3'b000, {(DW-1){1'b1}}});
   localparam logic signed [AW-1:0] MIN_V = $signed({3'b111, {(DW-1){1'b0}}});

   typedef enum logic [1:0] {S_LOAD, S_CALC, S_UNLOAD} state_t;

   state_t               state_q, state_d;
   logic [LOG2N-1:0]     idx_q, idx_d;
   logic [SW-1:0]        stage_q, stage_d;
   logic [HB-1:0]        bfly_q, bfly_d;
   logic                 inv_q, inv_d;
   logic signed [DW-1:0] re_q [N];
   logic signed [DW-1:0] re_d [N];
   logic signed [DW-1:0] im_q [N];
   logic signed [DW-1:0] im_d [N];

   logic [LOG2N-1:0]     top_a, bot_a;
   logic [3:0]           rom_m;
   logic signed [TW-1:0] w_re, w_im;
   logic signed [DW-1:0] a_re, a_im, b_re, b_im;
   logic signed [PW-1:0] br_x, bi_x, wr_x, wi_x, pr, pi;
   logic signed [AW-1:0] t_re, t_im, a_xr, a_xi, s_re, s_im, d_re, d_im;

   function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
      logic [LOG2N-1:0] r;
      for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
      return r;
   endfunction

   // cos(2*pi*m/32) scaled by 2^14, rounded to nearest
   function automatic int rom_cos(input logic [3:0] m);
      case (m)
         4'd0:    return 16384;
         4'd1:    return 16069;
         4'd2:    return 15137;
         4'd3:    return 13623;
         4'd4:    return 11585;
         4'd5:    return 9102;
         4'd6:    return 6270;
         4'd7:    return 3196;
         4'd8:    return 0;
         4'd9:    return -3196;
         4'd10:   return -6270;
         4'd11:   return -9102;
         4'd12:   return -11585;
         4'd13:   return -13623;
         4'd14:   return -15137;
         default: return -16069;
      endcase
   endfunction

   // sin(2*pi*m/32) = cos(2*pi*|m-8|/32) over m = 0..15
   function automatic int rom_sin(input logic [3:0] m);
      return rom_cos(m[3] ? (m - 4'd8) : (4'd8 - m));
   endfunction

   function automatic logic signed [DW-1:0] sat(input logic signed [AW-1:0] v);
      if (v > MAX_V) return MAX_V[DW-1:0];
      else if (v < MIN_V) return MIN_V[DW-1:0];
      else return v[DW-1:0];
   endfunction

   // Butterfly addressing, twiddle lookup and arithmetic for the current (stage, bfly)
   always_comb begin
      int s_i, b_i, h_i, top_i, k_i, c_i, sn_i;
      s_i   = int'(stage_q);
      b_i   = int'(bfly_q);
      h_i   = 1 << s_i;
      top_i = ((b_i >> s_i) << (s_i + 1)) + (b_i & (h_i - 1));
      k_i   = (b_i & (h_i - 1)) << (LOG2N - 1 - s_i);
      top_a = LOG2N'(top_i);
      bot_a = LOG2N'(top_i + h_i);
      // The ROM is laid out for 32 points; smaller N strides through it.
      rom_m = 4'(k_i << (5 - LOG2N));
      c_i   = (rom_cos(rom_m) <<< TW_UP) >>> TW_DN;
      sn_i  = (rom_sin(rom_m) <<< TW_UP) >>> TW_DN;
      w_re  = TW'(c_i);
      w_im  = TW'(inv_q ? sn_i : -sn_i);

      a_re = re_q[top_a];
      a_im = im_q[top_a];
      b_re = re_q[bot_a];
      b_im = im_q[bot_a];
      br_x = PW'(b_re);
      bi_x = PW'(b_im);
      wr_x = PW'(w_re);
      wi_x = PW'(w_im);
      pr   = (br_x * wr_x) - (bi_x * wi_x);
      pi   = (br_x * wi_x) + (bi_x * wr_x);
      t_re = AW'(pr >>> (TW - 2));
      t_im = AW'(pi >>> (TW - 2));
      a_xr = AW'(a_re);
      a_xi = AW'(a_im);
      s_re = a_xr + t_re;
      s_im = a_xi + t_im;
      d_re = a_xr - t_re;
      d_im = a_xi - t_im;
      if (SCALE != 0) begin
         s_re = s_re >>> 1;
         s_im = s_im >>> 1;
         d_re = d_re >>> 1;
         d_im = d_im >>> 1;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      stage_d   = stage_q;
      bfly_d    = bfly_q;
      inv_d     = inv_q;
      re_d      = re_q;
      im_d      = im_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      data_out  = '0;
      case (state_q)
         S_LOAD: begin
            in_ready = 1'b1;
            if (in_valid) begin
               re_d[bitrev(idx_q)] = data_in[2*DW-1:DW];
               im_d[bitrev(idx_q)] = data_in[DW-1:0];
               if (idx_q == '0) inv_d = inverse;
               if (idx_q == LAST_IDX) begin
                  idx_d   = '0;
                  state_d = S_CALC;
               end else begin
                  idx_d = idx_q + LOG2N'(1);
               end
            end
         end
         S_CALC: begin
            busy        = 1'b1;
            re_d[top_a] = sat(s_re);
            im_d[top_a] = sat(s_im);
            re_d[bot_a] = sat(d_re);
            im_d[bot_a] = sat(d_im);
            if (bfly_q == LAST_B) begin
               bfly_d = '0;
               if (stage_q == LAST_S) begin
                  stage_d = '0;
                  state_d = S_UNLOAD;
               end else begin
                  stage_d = stage_q + SW'(1);
               end
            end else begin
               bfly_d = bfly_q + HB'(1);
            end
         end
         S_UNLOAD: begin
            out_valid = 1'b1;
            data_out  = {re_q[idx_q], im_q[idx_q]};
            if (out_ready) begin
               if (idx_q == LAST_IDX) begin
                  idx_d   = '0;
                  state_d = S_LOAD;
               end else begin
                  idx_d = idx_q + LOG2N'(1);
               end
            end
         end
         default: state_d = S_LOAD;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_LOAD;
         idx_q   <= '0;
         stage_q <= '0;
         bfly_q  <= '0;
         inv_q   <= 1'b0;
         for (int i = 0; i < N; i++) begin
            re_q[i] <= '0;
            im_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         stage_q <= stage_d;
         bfly_q  <= bfly_d;
         inv_q   <= inv_d;
         re_q    <= re_d;
         im_q    <= im_d;
      end
   end
endmodule
